pll_lock_sequencer: RTL and testbench

Sequences bring-up of the SDRAM clock PLL (80 MHz system clock plus phase-shifted SDRAM clock) from the free-running 50 MHz reference clock. Pulses the PLL reset, waits for lock with timeout/retry, and requires lock to hold for a qualification window. Only then does it release the synchronous-domain system reset and flag readiness to the SDRAM controller. On loss of lock or a software relock request it re-asserts system reset and restarts the sequence.

---
 rtl/pll_lock_sequencer.sv | 108 ++++++++++
 tb/tb_pll_lock_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: pulses the PLL reset, waits for lock with timeout/retry, qualifies lock,
// then releases the system reset; restarts on lock loss or a relock request.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int SYNC_STAGES        = 2,
    parameter int RETRY_W            = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               ready,
    output logic [2:0]         state,
    output logic [RETRY_W-1:0] retry_count,
    output logic               lock_lost
);
    localparam int CMAX_A = PLL_RST_CYCLES > LOCK_STABLE_CYCLES ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CMAX   = CMAX_A > LOCK_TIMEOUT ? CMAX_A : LOCK_TIMEOUT;
    localparam int CW     = CMAX > 1 ? $clog2(CMAX) : 1;
    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_QUALIFY   = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   lock_s;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic [2:0]             state_nxt;
    logic [RETRY_W-1:0]     retry_nxt;

    assign lock_s    = sync[SYNC_STAGES-1];
    assign lock_lost = state == S_RUN && !lock_s && !relock_req;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        retry_nxt = retry_count;
        if (relock_req) begin
            state_nxt = S_PLL_RST;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = S_QUALIFY;
                        cnt_nxt   = '0;
                    end else if (cnt == TO_LAST) begin
                        state_nxt = S_PLL_RST;
                        cnt_nxt   = '0;
                        retry_nxt = &retry_count ? retry_count : retry_count + 1'b1;
                    end
                end
                S_QUALIFY: begin
                    if (!lock_s) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end
                end
                S_RUN: begin
                    cnt_nxt   = '0;
                    state_nxt = lock_s ? S_RUN : S_PLL_RST;
                end
                default: begin
                    state_nxt = S_PLL_RST;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Reset-type outputs are decoded from the next state so they come straight off flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync        <= '0;
            state       <= S_PLL_RST;
            cnt         <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            sys_rst_n   <= 1'b0;
            ready       <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], pll_locked};
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_count <= retry_nxt;
            pll_rst     <= state_nxt == S_PLL_RST;
            sys_rst_n   <= state_nxt == S_RUN;
            ready       <= state_nxt == S_RUN;
        end
    end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed stimulus with a phase/duration model of the sequencer,
// checked every cycle, plus hand-computed latency and counter expectations.
module tb_pll_lock_sequencer;
    localparam int PRC  = 16;
    localparam int LSC  = 8;
    localparam int TO   = 32;
    localparam int SYNC = 2;
    localparam int RW   = 2;
    localparam int P_RST = 0, P_WAIT = 1, P_QUAL = 2, P_RUN = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pll_locked;
    logic          relock_req;
    logic          pll_rst;
    logic          sys_rst_n;
    logic          ready;
    logic [2:0]    state;
    logic [RW-1:0] retry_count;
    logic          lock_lost;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    int m_ph = 0;
    int m_t  = 0;
    int m_to = 0;
    int ecnt = 0;
    bit smp [64];

    int prst_run = 0, last_prst = 0, qual_run = 0, last_qual = 0, ll_pulses = 0;
    int n, ll0;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT(TO),
        .SYNC_STAGES(SYNC), .RETRY_W(RW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .relock_req(relock_req),
        .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .state(state),
        .retry_count(retry_count), .lock_lost(lock_lost)
    );

    always #10 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // The synchronised lock seen by the sequencer is the pll_locked sample taken SYNC edges ago.
    function automatic bit lock_s_now();
        return ecnt >= SYNC ? smp[(ecnt - SYNC) % 64] : 1'b0;
    endfunction

    function automatic int dur(input int ph);
        return ph == P_RST ? PRC : ph == P_WAIT ? TO : LSC;
    endfunction

    function automatic int after(input int ph);
        return ph == P_RST ? P_WAIT : ph == P_WAIT ? P_RST : P_RUN;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ph <= P_RST;
            m_t  <= 0;
            m_to <= 0;
            ecnt <= 0;
        end else begin
            smp[ecnt % 64] <= pll_locked;
            ecnt <= ecnt + 1;
            if (relock_req) begin
                m_ph <= P_RST;
                m_t  <= 0;
            end else if (m_ph == P_RUN) begin
                if (!lock_s_now()) m_ph <= P_RST;
                m_t <= 0;
            end else if (m_ph == P_WAIT && lock_s_now()) begin
                m_ph <= P_QUAL;
                m_t  <= 0;
            end else if (m_ph == P_QUAL && !lock_s_now()) begin
                m_ph <= P_WAIT;
                m_t  <= 0;
            end else if (m_t + 1 == dur(m_ph)) begin
                m_ph <= after(m_ph);
                m_t  <= 0;
                if (m_ph == P_WAIT) m_to <= m_to + 1;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("state", int'(state), m_ph);
            check("pll_rst", int'(pll_rst), int'(m_ph == P_RST));
            check("sys_rst_n", int'(sys_rst_n), int'(m_ph == P_RUN));
            check("ready", int'(ready), int'(m_ph == P_RUN));
            check("retry_count", int'(retry_count), m_to > 3 ? 3 : m_to);
            check("lock_lost", int'(lock_lost), int'(m_ph == P_RUN && !lock_s_now() && !relock_req));
        end
        if (!reset_n) begin
            prst_run <= 0;
            qual_run <= 0;
        end else begin
            prst_run <= pll_rst ? prst_run + 1 : 0;
            if (!pll_rst && prst_run != 0) last_prst <= prst_run;
            qual_run <= state == 3'd2 ? qual_run + 1 : 0;
            if (state == 3'd3 && qual_run != 0) last_qual <= qual_run;
            ll_pulses <= ll_pulses + int'(lock_lost);
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_state(input string nm, input logic [2:0] s, input int budget);
        int k = 0;
        while (state != s && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        check({"reach_", nm}, int'(state), int'(s));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_pll_rst"}, int'(pll_rst), 1);
        check({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
        check({tag, "_ready"}, int'(ready), 0);
        check({tag, "_retry"}, int'(retry_count), 0);
        check({tag, "_lock_lost"}, int'(lock_lost), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_on = 1'b1;
        chk_reset("por");
        // lock already high at release: 16 reset cycles, 1 in WAIT_LOCK, 8 qualifying
        pll_locked = 1'b1;
        reset_n = 1'b1;
        n = 0;
        while (!ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_edges", n, 25);
        tick(2);
        check("first_prst_len", last_prst, 16);
        check("first_qual_len", last_qual, 8);
        check("run_sys_rst_n", int'(sys_rst_n), 1);
        // three timeouts before lock appears
        reset_n = 1'b0;
        tick(2);
        pll_locked = 1'b0;
        reset_n = 1'b1;
        tick(150);
        pll_locked = 1'b1;
        wait_state("run_after_retry", 3'd3, 300);
        check("retry_three", int'(retry_count), 3);
        check("model_timeouts3", m_to, 3);
        check("retry_prst_len", last_prst, 16);
        // one-cycle lock glitch while qualifying
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        wait_state("qualify", 3'd2, 100);
        tick(3);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        wait_state("run_after_glitch", 3'd3, 100);
        tick(2);
        check("glitch_qual_len", last_qual, 8);
        check("glitch_retry", int'(retry_count), 0);
        // lock loss in RUN
        ll0 = ll_pulses;
        pll_locked = 1'b0;
        tick(6);
        pll_locked = 1'b1;
        wait_state("run_after_loss", 3'd3, 200);
        tick(2);
        check("loss_pulses", ll_pulses - ll0, 1);
        check("loss_prst_len", last_prst, 16);
        // relock request coincident with synced lock drop
        ll0 = ll_pulses;
        pll_locked = 1'b0;
        tick(2);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check("relock_state", int'(state), 0);
        tick(3);
        pll_locked = 1'b1;
        wait_state("run_after_relock", 3'd3, 200);
        tick(2);
        check("relock_pulses", ll_pulses - ll0, 0);
        check("relock_retry", int'(retry_count), 0);
        // async reset in the middle of QUALIFY with two retries logged
        reset_n = 1'b0;
        tick(2);
        pll_locked = 1'b0;
        reset_n = 1'b1;
        tick(100);
        pll_locked = 1'b1;
        wait_state("qualify_retry2", 3'd2, 200);
        check("retry_two", int'(retry_count), 2);
        tick(3);
        #5;
        reset_n = 1'b0;
        #1;
        chk_reset("async");
        // five timeouts saturate a 2-bit counter
        tick(2);
        pll_locked = 1'b0;
        reset_n = 1'b1;
        tick(250);
        pll_locked = 1'b1;
        wait_state("run_after_sat", 3'd3, 300);
        check("retry_sat", int'(retry_count), 3);
        check("model_timeouts5", m_to, 5);
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
